// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tt_pkg;

  localparam int unsigned N_IN  = 5;
  localparam int unsigned N_VEC = 32;

  localparam logic [N_VEC-1:0] INCISO2_MASK = 32'h0A3E8C5C;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSample,
    StCheck,
    StDone
  } state_e;

endpackage

// File: rtl/tt_sweeper_if.sv
// Control, stimulus and result signals between the sweeper and its environment.
interface tt_sweeper_if;
  import tt_pkg::*;

  logic             auto;
  logic             start;
  logic [N_IN-1:0]  sw;
  logic             f_in;
  logic             X, Y, Z, K, M;
  logic             busy;
  logic             done;
  logic             pass;
  logic [5:0]       err_cnt;
  logic [4:0]       first_bad;
  logic [N_VEC-1:0] tt;

  modport master (
    output auto, start, sw, f_in,
    input  X, Y, Z, K, M, busy, done, pass, err_cnt, first_bad, tt
  );

  modport slave (
    input  auto, start, sw, f_in,
    output X, Y, Z, K, M, busy, done, pass, err_cnt, first_bad, tt
  );

endinterface

// File: rtl/sw_sync.sv
// Two-flop synchroniser for the board switches, synchronous active-high reset.
module sw_sync
  import tt_pkg::*;
#(
  parameter int unsigned Width = N_IN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] stage1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_q <= '0;
      q        <= '0;
    end else begin
      stage1_q <= d;
      q        <= stage1_q;
    end
  end

endmodule

// File: rtl/tt_sweeper.sv
// Drives all 32 input vectors into the SOP block, captures its truth table and
// compares it against a golden mask; manual mode forwards synchronised switches.
module tt_sweeper
  import tt_pkg::*;
#(
  parameter int unsigned      SETTLE   = 2,
  parameter logic [N_VEC-1:0] EXP_MASK = INCISO2_MASK
) (
  input logic         clk,
  input logic         rst,
  tt_sweeper_if.slave bus
);

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  logic [N_IN-1:0]  sw_s;
  state_e           state_q;
  logic [4:0]       idx_q;
  logic [3:0]       cnt_q;
  logic [4:0]       vec_q;
  logic             busy_q, done_q, pass_q;
  logic [5:0]       err_q;
  logic [4:0]       first_q;
  logic [N_VEC-1:0] tt_q;

  logic [N_VEC-1:0] miss;
  logic [5:0]       miss_cnt;
  logic [4:0]       first_miss;
  logic             launch;
  logic             abort;
  logic [4:0]       vec_out;

  sw_sync #(.Width(N_IN)) u_sw_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.sw),
    .q   (sw_s)
  );

  // Scan downward so the lowest mismatching index is the one left standing.
  always_comb begin
    miss       = tt_q ^ EXP_MASK;
    miss_cnt   = '0;
    first_miss = '0;
    for (int i = int'(N_VEC) - 1; i >= 0; i--) begin
      miss_cnt = miss_cnt + {5'd0, miss[i]};
      if (miss[i]) first_miss = 5'(i);
    end
  end

  // busy_q is set exactly in DRIVE/SAMPLE/CHECK, so it doubles as the abort window.
  assign launch = bus.start && bus.auto && !busy_q;
  assign abort  = busy_q && !bus.auto;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
      tt_q    <= '0;
    end else if (launch) begin
      state_q <= StDrive;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
      tt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StDrive: begin
          if (cnt_q == SettleLast) state_q <= StSample;
          else                     cnt_q   <= cnt_q + 4'd1;
        end
        StSample: begin
          tt_q[idx_q] <= bus.f_in;
          if (idx_q == 5'd31) begin
            state_q <= StCheck;
          end else begin
            idx_q   <= idx_q + 5'd1;
            vec_q   <= idx_q + 5'd1;
            cnt_q   <= '0;
            state_q <= StDrive;
          end
        end
        StCheck: begin
          err_q   <= miss_cnt;
          pass_q  <= (miss_cnt == 6'd0);
          first_q <= first_miss;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          if (!bus.auto) begin
            done_q  <= 1'b0;
            vec_q   <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign vec_out = (state_q == StIdle && !bus.auto) ? sw_s : vec_q;
  assign {bus.X, bus.Y, bus.Z, bus.K, bus.M} = vec_out;

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_cnt   = err_q;
  assign bus.first_bad = first_q;
  assign bus.tt        = tt_q;

endmodule

// File: tb/tb_tt_sweeper.sv
// Randomised bench: a behavioural SOP block with fault injection feeds the sweeper.
module tb_tt_sweeper;
  import tt_pkg::*;

  localparam int unsigned Settle  = 2;
  localparam int          Latency = 32 * (Settle + 1) + 2;

  logic        clk;
  logic        rst;
  logic [31:0] golden_tt;
  logic [31:0] fault_mask;
  logic        stuck0;
  logic [4:0]  vec;
  int          n_vec;
  int          n_bad;

  tt_sweeper_if bus ();

  tt_sweeper #(
    .SETTLE   (Settle),
    .EXP_MASK (32'h0A3E8C5C)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign vec = {bus.X, bus.Y, bus.Z, bus.K, bus.M};

  function automatic logic fblock(input logic [4:0] v, input logic [31:0] fm, input logic st);
    if (st) return 1'b0;
    return golden_tt[v] ^ fm[v];
  endfunction

  always_comb bus.f_in = fblock(vec, fault_mask, stuck0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_done"},  32'(bus.done), 32'd0);
    check({tag, "_pass"},  32'(bus.pass), 32'd0);
    check({tag, "_err"},   32'(bus.err_cnt), 32'd0);
    check({tag, "_first"}, 32'(bus.first_bad), 32'd0);
    check({tag, "_tt"},    bus.tt, 32'd0);
  endtask

  task automatic run_sweep(input string tag, input logic [31:0] fm, input logic st,
                           input bit extra_start);
    logic [31:0] exp_tt;
    logic [31:0] diff;
    int          exp_first;
    int          k;
    fault_mask = fm;
    stuck0     = st;
    for (int v = 0; v < 32; v++) exp_tt[v] = fblock(5'(v), fm, st);
    diff      = exp_tt ^ golden_tt;
    exp_first = 0;
    for (int i = 0; i < 32; i++) begin
      if (diff[i]) begin
        exp_first = i;
        break;
      end
    end
    bus.auto  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 1;
    check({tag, "_busy_on"}, 32'(bus.busy), 32'd1);
    check({tag, "_done_off"}, 32'(bus.done), 32'd0);
    check({tag, "_tt_clr"}, bus.tt, 32'd0);
    while (!bus.done && k < 4 * Latency) begin
      if (extra_start && k == 10) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(Latency));
    check({tag, "_tt"}, bus.tt, exp_tt);
    check({tag, "_err"}, 32'(bus.err_cnt), 32'($countones(diff)));
    check({tag, "_pass"}, 32'(bus.pass), 32'(diff == 32'd0));
    check({tag, "_first"}, 32'(bus.first_bad), 32'(exp_first));
    check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
    check({tag, "_vec31"}, 32'(vec), 32'd31);
  endtask

  initial begin
    automatic int minterms[14] = '{2, 3, 4, 6, 10, 11, 15, 17, 18, 19, 20, 21, 25, 27};
    logic [4:0] prev_sw;
    logic [4:0] new_sw;
    n_vec      = 0;
    n_bad      = 0;
    golden_tt  = '0;
    foreach (minterms[i]) golden_tt[minterms[i]] = 1'b1;
    fault_mask = '0;
    stuck0     = 1'b0;
    rst        = 1'b1;
    bus.auto   = 1'b0;
    bus.start  = 1'b0;
    bus.sw     = '0;
    tick();
    tick();
    check("rst_vec", 32'(vec), 32'd0);
    check_cleared("rst");
    rst = 1'b0;

    // Manual mode: exactly two cycles of synchroniser delay.
    bus.sw = 5'b10101;
    tick();
    check("man_1cyc", 32'(vec), 32'd0);
    tick();
    check("man_2cyc", 32'(vec), 32'b10101);
    check("man_busy", 32'(bus.busy), 32'd0);
    check("man_done", 32'(bus.done), 32'd0);
    repeat (4) begin
      prev_sw = bus.sw;
      new_sw  = 5'($urandom);
      bus.sw  = new_sw;
      tick();
      check("man_rnd_old", 32'(vec), 32'(prev_sw));
      tick();
      check("man_rnd_new", 32'(vec), 32'(new_sw));
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("man_start_ign", 32'(bus.busy), 32'd0);
    bus.auto = 1'b1;
    tick();
    check("auto_idle_vec", 32'(vec), 32'd0);

    run_sweep("golden", 32'd0, 1'b0, 1'b0);
    run_sweep("flt0_27", 32'h0800_0001, 1'b0, 1'b0);
    check("flt0_27_lit", bus.tt, 32'h023E8C5D);
    run_sweep("flt27", 32'h0800_0000, 1'b0, 1'b0);
    check("flt27_first_lit", 32'(bus.first_bad), 32'd27);
    run_sweep("stuck0", 32'd0, 1'b1, 1'b0);
    check("stuck0_err_lit", 32'(bus.err_cnt), 32'd14);
    check("stuck0_first_lit", 32'(bus.first_bad), 32'd2);
    run_sweep("rerun", 32'd0, 1'b0, 1'b0);
    run_sweep("dbl_start", 32'd0, 1'b0, 1'b1);

    // Abort at cycle 40, with a coincident start that must lose.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (39) tick();
    bus.auto  = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_cleared("abort");
    check("abort_vec", 32'(vec), 32'(bus.sw));
    tick();
    check("abort_stay", 32'(bus.busy), 32'd0);

    // Reset at cycle 60 of another sweep.
    bus.auto  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (59) tick();
    rst = 1'b1;
    tick();
    check_cleared("midrst");
    check("midrst_vec", 32'(vec), 32'd0);
    rst = 1'b0;

    repeat (3) begin
      run_sweep("rnd", $urandom & $urandom & $urandom, 1'b0, bit'($urandom_range(0, 1)));
    end

    bus.auto = 1'b0;
    tick();
    check("done_exit", 32'(bus.done), 32'd0);
    tick();
    check("done_exit_vec", 32'(vec), 32'(bus.sw));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
